// File: rtl/decoder_scan_sequencer.sv
// Channel address sequencer for the 3-to-8 one-hot decoder: steps a0..a2 through
// channels with a programmable dwell, single-pass or continuous. Optional macro SCAN_MASK_EN.
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_mode_cont,
    input  logic [DWELL_W-1:0] i_dwell,
`ifdef SCAN_MASK_EN
    input  logic [7:0]         i_ch_mask,
`endif
    output logic               o_a0,
    output logic               o_a1,
    output logic               o_a2,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_step,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    // Lowest set bit strictly above ch; bit 3 of the result flags that one exists.
    function automatic logic [3:0] next_above(input logic [7:0] mask, input logic [2:0] ch);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(ch))) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] mask);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

    state_t             r_state;
    logic [2:0]         r_ch;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell_l;
    logic               r_mode_l;
    logic [7:0]         r_mask;
    logic               r_valid;
    logic               r_busy;
    logic               r_step;
    logic               r_done;

    state_t             w_next_state;
    logic [2:0]         w_next_ch;
    logic [DWELL_W-1:0] w_next_cnt;
    logic [DWELL_W-1:0] w_next_dwell_l;
    logic               w_next_mode_l;
    logic [7:0]         w_next_mask;
    logic               w_next_valid;
    logic               w_next_busy;
    logic               w_next_step;
    logic               w_next_done;
    logic [7:0]         w_mask_in;
    logic [DWELL_W-1:0] w_dwell_in;
    logic [3:0]         w_next_hit;

`ifdef SCAN_MASK_EN
    assign w_mask_in = i_ch_mask;
`else
    assign w_mask_in = 8'hFF;
`endif

    assign w_dwell_in = (i_dwell == {DWELL_W{1'b0}}) ? DWELL_ONE : i_dwell;
    assign w_next_hit = next_above(r_mask, r_ch);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_next_state   = r_state;
        w_next_ch      = 3'd0;
        w_next_cnt     = r_cnt;
        w_next_dwell_l = r_dwell_l;
        w_next_mode_l  = r_mode_l;
        w_next_mask    = r_mask;
        w_next_valid   = 1'b0;
        w_next_busy    = 1'b0;
        w_next_step    = 1'b0;
        w_next_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop && (w_mask_in != 8'h00)) begin
                    w_next_state   = ST_SCAN;
                    w_next_ch      = lowest_set(w_mask_in);
                    w_next_cnt     = w_dwell_in;
                    w_next_dwell_l = w_dwell_in;
                    w_next_mode_l  = i_mode_cont;
                    w_next_mask    = w_mask_in;
                    w_next_valid   = 1'b1;
                    w_next_busy    = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (i_stop) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = {DWELL_W{1'b0}};
                end else if (r_cnt <= DWELL_ONE) begin
                    // Dwell expired: advance, wrap, or close out a single pass.
                    if (w_next_hit[3]) begin
                        w_next_ch    = w_next_hit[2:0];
                        w_next_cnt   = r_dwell_l;
                        w_next_valid = 1'b1;
                        w_next_busy  = 1'b1;
                        w_next_step  = 1'b1;
                    end else if (r_mode_l) begin
                        w_next_ch    = lowest_set(r_mask);
                        w_next_cnt   = r_dwell_l;
                        w_next_valid = 1'b1;
                        w_next_busy  = 1'b1;
                        w_next_step  = 1'b1;
                    end else begin
                        w_next_state = ST_FINISH;
                        w_next_cnt   = {DWELL_W{1'b0}};
                        w_next_busy  = 1'b1;
                        w_next_done  = 1'b1;
                    end
                end else begin
                    w_next_ch    = r_ch;
                    w_next_cnt   = r_cnt - DWELL_ONE;
                    w_next_valid = 1'b1;
                    w_next_busy  = 1'b1;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = {DWELL_W{1'b0}};
            end
        endcase
    end

    // State, counters, latched configuration and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ch      <= 3'd0;
            r_cnt     <= {DWELL_W{1'b0}};
            r_dwell_l <= DWELL_ONE;
            r_mode_l  <= 1'b0;
            r_mask    <= 8'h00;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_step    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ch      <= w_next_ch;
            r_cnt     <= w_next_cnt;
            r_dwell_l <= w_next_dwell_l;
            r_mode_l  <= w_next_mode_l;
            r_mask    <= w_next_mask;
            r_valid   <= w_next_valid;
            r_busy    <= w_next_busy;
            r_step    <= w_next_step;
            r_done    <= w_next_done;
        end
    end

    assign o_a0    = r_ch[2];
    assign o_a1    = r_ch[1];
    assign o_a2    = r_ch[0];
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_step  = r_step;
    assign o_done  = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed self-checking bench for decoder_scan_sequencer; mask tests need SCAN_MASK_EN.
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode_cont;
    logic [7:0] dwell;
    logic [7:0] ch_mask;
    logic       a0, a1, a2, valid, busy, step, done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_mode_cont (mode_cont),
        .i_dwell     (dwell),
`ifdef SCAN_MASK_EN
        .i_ch_mask   (ch_mask),
`endif
        .o_a0        (a0),
        .o_a1        (a1),
        .o_a2        (a2),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_step      (step),
        .o_done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status word {addr[2:0], valid, busy, step, done}
    task automatic chk(input string tag, input logic [2:0] ea, input logic ev,
                       input logic eb, input logic es, input logic ed);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {a0, a1, a2, valid, busy, step, done};
        exp = {ea, ev, eb, es, ed};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b (addr,valid,busy,step,done)", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        dwell = 8'd3; ch_mask = 8'hFF;

        // 1: reset state
        tick(); chk("reset0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); chk("reset1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); chk("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: single pass, dwell 3
        start = 1'b1; dwell = 8'd3; mode_cont = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                start = 1'b0;
                chk("single_d3", 3'(c), 1'b1, 1'b1, (k == 0 && c != 0), 1'b0);
            end
        end
        tick(); chk("single_done", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); chk("single_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: continuous, dwell 1, wrap then stop at address 4
        start = 1'b1; dwell = 8'd1; mode_cont = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            start = 1'b0;
            chk("cont_d1", 3'(i % 8), 1'b1, 1'b1, (i != 0), 1'b0);
        end
        stop = 1'b1;
        tick(); chk("cont_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        tick(); chk("cont_stop_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: dwell 0 behaves as 1; restart attempt mid-scan is ignored
        start = 1'b1; dwell = 8'd0; mode_cont = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = (i == 2);
            if (i == 2) dwell = 8'd9;
            chk("d0_scan", 3'(i), 1'b1, 1'b1, (i != 0), 1'b0);
        end
        start = 1'b0;
        tick(); chk("d0_done", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(); chk("d0_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: start with stop in IDLE is ignored
        start = 1'b1; stop = 1'b1; dwell = 8'd1;
        tick(); chk("startstop0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); chk("startstop1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;

        // 5: stop coinciding with final expiry of a single pass
        start = 1'b1; dwell = 8'd1; mode_cont = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            chk("stop7_scan", 3'(i), 1'b1, 1'b1, (i != 0), 1'b0);
        end
        stop = 1'b1;
        tick(); chk("stop7_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        tick(); chk("stop7_nodone", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // continuous dwell 2 wrap: step lands on first cycle of channel 0
        start = 1'b1; dwell = 8'd2; mode_cont = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            start = 1'b0;
            chk("cont_d2", 3'((i / 2) % 8), 1'b1, 1'b1, (i != 0 && i % 2 == 0), 1'b0);
        end

        // reset mid-scan: takes effect at the next edge, no done
        rst = 1'b1;
        tick(); chk("rst_mid0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); chk("rst_mid1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); chk("rst_mid_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_MASK_EN
        // 6: masked single pass 2,2,5,5,7,7
        begin
            logic [2:0] exp_addr [6];
            exp_addr = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
            start = 1'b1; dwell = 8'd2; mode_cont = 1'b0; ch_mask = 8'b1010_0100;
            for (int i = 0; i < 6; i++) begin
                tick();
                start = 1'b0;
                chk("mask_scan", exp_addr[i], 1'b1, 1'b1, (i == 2 || i == 4), 1'b0);
            end
            tick(); chk("mask_done", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            tick(); chk("mask_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // single enabled channel, continuous: address held, step every dwell
        start = 1'b1; dwell = 8'd2; mode_cont = 1'b1; ch_mask = 8'b0000_1000;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            chk("mask_one", 3'd3, 1'b1, 1'b1, (i != 0 && i % 2 == 0), 1'b0);
        end
        stop = 1'b1;
        tick(); chk("mask_one_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        // empty mask: start ignored
        start = 1'b1; ch_mask = 8'h00;
        tick(); chk("mask_zero0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); chk("mask_zero1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
